// File: rtl/risc_pkg.sv
// Shared constants for the RISC control path: opcodes, ALU codes, FSM state
// encodings, instruction classes and the control-strobe bundle.
package risc_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_INC  = 5'b11111;

  // FSM state encodings (kept as plain constants for legacy compatibility)
  localparam logic [3:0] S_FETCH0 = 4'd0;
  localparam logic [3:0] S_FETCH1 = 4'd1;
  localparam logic [3:0] S_FETCH2 = 4'd2;
  localparam logic [3:0] S_EX3    = 4'd3;
  localparam logic [3:0] S_EX4    = 4'd4;
  localparam logic [3:0] S_EX5    = 4'd5;
  localparam logic [3:0] S_EX6    = 4'd6;
  localparam logic [3:0] S_EX7    = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;

  // Instruction classes sharing a common microsequence
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_IMM,
    CLS_LDI,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_HALT
  } instr_class_t;

  // One cycle's worth of datapath strobes
  typedef struct packed {
    logic       pc_in;
    logic       pc_out;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       y_in;
    logic       z_in;
    logic       zlo_out;
    logic       c_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       con_in;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] alu_code;
  } ctrl_t;

endpackage

// File: rtl/control_unit_op_decode.sv
// Opcode decoder: maps the 5-bit opcode to an instruction class and the
// ALU operation used by that instruction's arithmetic step.
module op_decode
  import risc_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t cls,
  output logic [4:0]   alu_op
);

  // Classify the opcode; anything unlisted falls through to nop
  always_comb begin
    cls    = CLS_NOP;
    alu_op = ALU_NONE;
    case (opcode)
      OP_ADD:  begin cls = CLS_RTYPE; alu_op = ALU_ADD; end
      OP_SUB:  begin cls = CLS_RTYPE; alu_op = ALU_SUB; end
      OP_AND:  begin cls = CLS_RTYPE; alu_op = ALU_AND; end
      OP_OR:   begin cls = CLS_RTYPE; alu_op = ALU_OR;  end
      OP_ADDI: begin cls = CLS_IMM;   alu_op = ALU_ADD; end
      OP_ANDI: begin cls = CLS_IMM;   alu_op = ALU_AND; end
      OP_ORI:  begin cls = CLS_IMM;   alu_op = ALU_OR;  end
      OP_LDI:  begin cls = CLS_LDI;   alu_op = ALU_ADD; end
      OP_LD:   begin cls = CLS_LD;    alu_op = ALU_ADD; end
      OP_ST:   begin cls = CLS_ST;    alu_op = ALU_ADD; end
      OP_BR:   begin cls = CLS_BR;    alu_op = ALU_ADD; end
      OP_HALT: cls = CLS_HALT;
      default: begin cls = CLS_NOP; alu_op = ALU_NONE; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM for the RISC datapath. Every state lasts one clock;
// strobes are decoded from the registered state, IR and ConOut.
module control_unit
  import risc_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        ConOut,
  output logic        run,
  output logic        PCIn,
  output logic        PCOut,
  output logic        IRIn,
  output logic        MARIn,
  output logic        MDRIn,
  output logic        MDROut,
  output logic        YIn,
  output logic        ZIn,
  output logic        ZLoOut,
  output logic        COut,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        RIn,
  output logic        ROut,
  output logic        BAOut,
  output logic        Conin,
  output logic        memread,
  output logic        memwrite,
  output logic [4:0]  ALUCode
);

  logic [3:0]   state;
  logic [3:0]   state_next;
  instr_class_t cls;
  logic [4:0]   alu_op;
  ctrl_t        c;

  op_decode u_op_decode (
    .opcode (IR[31:27]),
    .cls    (cls),
    .alu_op (alu_op)
  );

  // State register with synchronous clear back to FETCH0
  always_ff @(posedge clock) begin
    if (clear) state <= S_FETCH0;
    else       state <= state_next;
  end

  // Sequencing: instruction length is set by the class in EX3/EX5/EX6
  always_comb begin
    state_next = S_FETCH0;
    case (state)
      S_FETCH0: state_next = S_FETCH1;
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: state_next = S_EX3;
      S_EX3: begin
        case (cls)
          CLS_HALT: state_next = S_HALT;
          CLS_NOP:  state_next = S_FETCH0;
          default:  state_next = S_EX4;
        endcase
      end
      S_EX4: state_next = S_EX5;
      S_EX5: begin
        case (cls)
          CLS_LD, CLS_ST, CLS_BR: state_next = S_EX6;
          default:                state_next = S_FETCH0;
        endcase
      end
      S_EX6: begin
        case (cls)
          CLS_LD, CLS_ST: state_next = S_EX7;
          default:        state_next = S_FETCH0;
        endcase
      end
      S_EX7:   state_next = S_FETCH0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH0;
    endcase
  end

  // Strobe decode per state; clear blanks every strobe while it is held
  always_comb begin
    c = '0;
    case (state)
      S_FETCH0: begin
        c.pc_out   = 1'b1;
        c.mar_in   = 1'b1;
        c.z_in     = 1'b1;
        c.alu_code = ALU_INC;
      end
      S_FETCH1: begin
        c.zlo_out  = 1'b1;
        c.pc_in    = 1'b1;
        c.mem_read = 1'b1;
        c.mdr_in   = 1'b1;
      end
      S_FETCH2: begin
        c.mdr_out = 1'b1;
        c.ir_in   = 1'b1;
      end
      S_EX3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
          end
          CLS_BR: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX4: begin
        case (cls)
          CLS_RTYPE: begin
            c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_code = alu_op;
          end
          CLS_IMM: begin
            c.c_out = 1'b1; c.z_in = 1'b1; c.alu_code = alu_op;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            c.c_out = 1'b1; c.z_in = 1'b1; c.alu_code = ALU_ADD;
          end
          CLS_BR: begin
            c.pc_out = 1'b1; c.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX5: begin
        case (cls)
          CLS_RTYPE, CLS_IMM, CLS_LDI: begin
            c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            c.zlo_out = 1'b1; c.mar_in = 1'b1;
          end
          CLS_BR: begin
            c.c_out = 1'b1; c.z_in = 1'b1; c.alu_code = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_EX6: begin
        case (cls)
          CLS_LD: begin
            c.mem_read = 1'b1; c.mdr_in = 1'b1;
          end
          CLS_ST: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
          end
          CLS_BR: begin
            c.zlo_out = ConOut; c.pc_in = ConOut;
          end
          default: ;
        endcase
      end
      S_EX7: begin
        case (cls)
          CLS_LD: begin
            c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          CLS_ST:  c.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    if (clear) c = '0;
  end

  // run stays high through clear even if the held state is HALT
  always_comb begin
    run = clear || (state != S_HALT);
  end

  // Port fan-out from the strobe bundle
  always_comb begin
    PCIn     = c.pc_in;
    PCOut    = c.pc_out;
    IRIn     = c.ir_in;
    MARIn    = c.mar_in;
    MDRIn    = c.mdr_in;
    MDROut   = c.mdr_out;
    YIn      = c.y_in;
    ZIn      = c.z_in;
    ZLoOut   = c.zlo_out;
    COut     = c.c_out;
    Gra      = c.gra;
    Grb      = c.grb;
    Grc      = c.grc;
    RIn      = c.r_in;
    ROut     = c.r_out;
    BAOut    = c.ba_out;
    Conin    = c.con_in;
    memread  = c.mem_read;
    memwrite = c.mem_write;
    ALUCode  = c.alu_code;
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction microstep lists are
// built from the instruction tables and compared cycle by cycle.
module tb_control_unit;
  import risc_pkg::OP_LD, risc_pkg::OP_LDI, risc_pkg::OP_ST, risc_pkg::OP_ADD,
         risc_pkg::OP_SUB, risc_pkg::OP_AND, risc_pkg::OP_OR, risc_pkg::OP_ADDI,
         risc_pkg::OP_ANDI, risc_pkg::OP_ORI, risc_pkg::OP_BR, risc_pkg::OP_HALT;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = '0;
  logic        ConOut = 1'b0;
  logic        run, PCIn, PCOut, IRIn, MARIn, MDRIn, MDROut, YIn, ZIn, ZLoOut;
  logic        COut, Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite;
  logic [4:0]  ALUCode;

  int n_cmp = 0;
  int n_bad = 0;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .ConOut(ConOut), .run(run),
    .PCIn(PCIn), .PCOut(PCOut), .IRIn(IRIn), .MARIn(MARIn), .MDRIn(MDRIn),
    .MDROut(MDROut), .YIn(YIn), .ZIn(ZIn), .ZLoOut(ZLoOut), .COut(COut),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut),
    .Conin(Conin), .memread(memread), .memwrite(memwrite), .ALUCode(ALUCode)
  );

  always #5 clock = ~clock;

  localparam logic [18:0] M_PCIN  = 19'd1 << 0;
  localparam logic [18:0] M_PCOUT = 19'd1 << 1;
  localparam logic [18:0] M_IRIN  = 19'd1 << 2;
  localparam logic [18:0] M_MARIN = 19'd1 << 3;
  localparam logic [18:0] M_MDRIN = 19'd1 << 4;
  localparam logic [18:0] M_MDROUT= 19'd1 << 5;
  localparam logic [18:0] M_YIN   = 19'd1 << 6;
  localparam logic [18:0] M_ZIN   = 19'd1 << 7;
  localparam logic [18:0] M_ZLO   = 19'd1 << 8;
  localparam logic [18:0] M_COUT  = 19'd1 << 9;
  localparam logic [18:0] M_GRA   = 19'd1 << 10;
  localparam logic [18:0] M_GRB   = 19'd1 << 11;
  localparam logic [18:0] M_GRC   = 19'd1 << 12;
  localparam logic [18:0] M_RIN   = 19'd1 << 13;
  localparam logic [18:0] M_ROUT  = 19'd1 << 14;
  localparam logic [18:0] M_BAOUT = 19'd1 << 15;
  localparam logic [18:0] M_CONIN = 19'd1 << 16;
  localparam logic [18:0] M_MRD   = 19'd1 << 17;
  localparam logic [18:0] M_MWR   = 19'd1 << 18;

  typedef struct {
    logic [18:0] m;
    logic [4:0]  alu;
    bit          cond;   // ZLoOut+PCIn added when ConOut is high this cycle
  } step_t;

  step_t exp_q[$];

  function automatic logic [18:0] obs();
    return {memwrite, memread, Conin, BAOut, ROut, RIn, Grc, Grb, Gra, COut,
            ZLoOut, ZIn, YIn, MDROut, MDRIn, MARIn, IRIn, PCOut, PCIn};
  endfunction

  function automatic void push(logic [18:0] m, logic [4:0] alu, bit cond);
    step_t s;
    s.m = m; s.alu = alu; s.cond = cond;
    exp_q.push_back(s);
  endfunction

  function automatic logic [4:0] alu_of(logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return 5'b00011;
      OP_SUB:          return 5'b00100;
      OP_AND, OP_ANDI: return 5'b00101;
      OP_OR,  OP_ORI:  return 5'b00110;
      default:         return 5'b00000;
    endcase
  endfunction

  // Reference microprogram for one instruction, from fetch to last step
  function automatic void model(logic [4:0] op);
    exp_q.delete();
    push(M_PCOUT | M_MARIN | M_ZIN, 5'b11111, 0);
    push(M_ZLO | M_PCIN | M_MRD | M_MDRIN, 5'b00000, 0);
    push(M_MDROUT | M_IRIN, 5'b00000, 0);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        push(M_GRB | M_ROUT | M_YIN, 0, 0);
        push(M_GRC | M_ROUT | M_ZIN, alu_of(op), 0);
        push(M_ZLO | M_GRA | M_RIN, 0, 0);
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        push(M_GRB | M_ROUT | M_YIN, 0, 0);
        push(M_COUT | M_ZIN, alu_of(op), 0);
        push(M_ZLO | M_GRA | M_RIN, 0, 0);
      end
      OP_LDI, OP_LD, OP_ST: begin
        push(M_GRB | M_BAOUT | M_YIN, 0, 0);
        push(M_COUT | M_ZIN, 5'b00011, 0);
        if (op == OP_LDI) push(M_ZLO | M_GRA | M_RIN, 0, 0);
        else              push(M_ZLO | M_MARIN, 0, 0);
        if (op == OP_LD) begin
          push(M_MRD | M_MDRIN, 0, 0);
          push(M_MDROUT | M_GRA | M_RIN, 0, 0);
        end
        if (op == OP_ST) begin
          push(M_GRA | M_ROUT | M_MDRIN, 0, 0);
          push(M_MWR, 0, 0);
        end
      end
      OP_BR: begin
        push(M_GRA | M_ROUT | M_CONIN, 0, 0);
        push(M_PCOUT | M_YIN, 0, 0);
        push(M_COUT | M_ZIN, 5'b00011, 0);
        push('0, 0, 1);
      end
      default: push('0, 0, 0);   // halt's EX3 and nop's EX3 are both empty
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if ({obs(), ALUCode, run} !== {19'd0, 5'd0, 1'b1}) begin
        n_bad++;
        $display("FAIL reset: got strobes=%h alu=%b run=%b want strobes=0 alu=0 run=1",
                 obs(), ALUCode, run);
      end
    end
  endtask

  task automatic test_add();
    logic [18:0] em;
    model(OP_ADD);
    foreach (exp_q[i]) begin
      @(negedge clock);
      if (i == 0) begin clear = 1'b0; IR = {OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0}; end
      ConOut = 1'($urandom);
      #1;
      em = exp_q[i].m;
      n_cmp++;
      if ({obs(), ALUCode, run} !== {em, exp_q[i].alu, 1'b1}) begin
        n_bad++;
        $display("FAIL add step%0d: got strobes=%h alu=%b run=%b want strobes=%h alu=%b run=1",
                 i, obs(), ALUCode, run, em, exp_q[i].alu);
      end
    end
  endtask

  task automatic test_ld();
    model(OP_LD);
    foreach (exp_q[i]) begin
      @(negedge clock);
      if (i == 0) IR = {OP_LD, 4'd1, 4'd2, 19'h55};
      ConOut = 1'($urandom);
      #1;
      n_cmp++;
      if ({obs(), ALUCode, run} !== {exp_q[i].m, exp_q[i].alu, 1'b1}) begin
        n_bad++;
        $display("FAIL ld step%0d: got strobes=%h alu=%b run=%b want strobes=%h alu=%b run=1",
                 i, obs(), ALUCode, run, exp_q[i].m, exp_q[i].alu);
      end
    end
  endtask

  task automatic test_br(input logic con);
    logic [18:0] em;
    model(OP_BR);
    foreach (exp_q[i]) begin
      @(negedge clock);
      if (i == 0) IR = {OP_BR, 4'd5, 4'd0, 19'h7fff0};
      ConOut = con;
      #1;
      em = exp_q[i].m | ((exp_q[i].cond && con) ? (M_ZLO | M_PCIN) : 19'd0);
      n_cmp++;
      if ({obs(), ALUCode, run} !== {em, exp_q[i].alu, 1'b1}) begin
        n_bad++;
        $display("FAIL br(con=%b) step%0d: got strobes=%h alu=%b run=%b want strobes=%h alu=%b run=1",
                 con, i, obs(), ALUCode, run, em, exp_q[i].alu);
      end
    end
  endtask

  task automatic test_st();
    model(OP_ST);
    foreach (exp_q[i]) begin
      @(negedge clock);
      if (i == 0) IR = {OP_ST, 4'd7, 4'd3, 19'h10};
      ConOut = 1'($urandom);
      #1;
      n_cmp++;
      if ({obs(), ALUCode, run} !== {exp_q[i].m, exp_q[i].alu, 1'b1}) begin
        n_bad++;
        $display("FAIL st step%0d: got strobes=%h alu=%b run=%b want strobes=%h alu=%b run=1",
                 i, obs(), ALUCode, run, exp_q[i].m, exp_q[i].alu);
      end
    end
  endtask

  task automatic test_halt();
    model(OP_HALT);
    foreach (exp_q[i]) begin
      @(negedge clock);
      if (i == 0) IR = {OP_HALT, 27'($urandom)};
      ConOut = 1'($urandom);
      #1;
      n_cmp++;
      if ({obs(), ALUCode, run} !== {exp_q[i].m, exp_q[i].alu, 1'b1}) begin
        n_bad++;
        $display("FAIL halt step%0d: got strobes=%h alu=%b run=%b want strobes=%h alu=%b run=1",
                 i, obs(), ALUCode, run, exp_q[i].m, exp_q[i].alu);
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      ConOut = 1'($urandom);
      IR = {OP_ADD, 27'($urandom)};
      #1;
      n_cmp++;
      if ({obs(), ALUCode, run} !== {19'd0, 5'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL halted cyc%0d: got strobes=%h alu=%b run=%b want strobes=0 alu=0 run=0",
                 k, obs(), ALUCode, run);
      end
    end
    @(negedge clock);
    clear = 1'b1;
    #1;
    n_cmp++;
    if ({obs(), ALUCode, run} !== {19'd0, 5'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL halt_clear: got strobes=%h alu=%b run=%b want strobes=0 alu=0 run=1",
               obs(), ALUCode, run);
    end
  endtask

  task automatic test_clear_mid();
    model(OP_LD);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) begin clear = 1'b0; IR = {OP_LD, 4'd1, 4'd2, 19'h55}; end
      if (i == 5) clear = 1'b1;
      ConOut = 1'($urandom);
      #1;
      n_cmp++;
      if (i < 5 && {obs(), ALUCode, run} !== {exp_q[i].m, exp_q[i].alu, 1'b1}) begin
        n_bad++;
        $display("FAIL clear_mid step%0d: got strobes=%h alu=%b run=%b want strobes=%h alu=%b run=1",
                 i, obs(), ALUCode, run, exp_q[i].m, exp_q[i].alu);
      end
      if (i == 5 && {obs(), ALUCode, run} !== {19'd0, 5'd0, 1'b1}) begin
        n_bad++;
        $display("FAIL clear_mid held: got strobes=%h alu=%b run=%b want strobes=0 alu=0 run=1",
                 obs(), ALUCode, run);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [18:0] em;
    logic [4:0]  valid [11] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND,
                                OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_BR};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0) op = valid[$urandom_range(0, 10)];
      else                           op = 5'($urandom);
      if (op == OP_HALT) op = OP_SUB;
      model(op);
      foreach (exp_q[i]) begin
        @(negedge clock);
        if (i == 0) begin clear = 1'b0; IR = {op, 27'($urandom)}; end
        ConOut = 1'($urandom);
        #1;
        em = exp_q[i].m | ((exp_q[i].cond && ConOut) ? (M_ZLO | M_PCIN) : 19'd0);
        n_cmp++;
        if ({obs(), ALUCode, run} !== {em, exp_q[i].alu, 1'b1}) begin
          n_bad++;
          $display("FAIL rand op=%b step%0d: got strobes=%h alu=%b run=%b want strobes=%h alu=%b run=1",
                   op, i, obs(), ALUCode, run, em, exp_q[i].alu);
        end
        n_cmp++;
        if ((memread && memwrite) || (RIn && ROut)) begin
          n_bad++;
          $display("FAIL exclusive op=%b step%0d: got mr=%b mw=%b rin=%b rout=%b want no pair high",
                   op, i, memread, memwrite, RIn, ROut);
        end
      end
    end
    model(OP_ADD);
    @(negedge clock);
    #1;
    n_cmp++;
    if ({obs(), ALUCode} !== {exp_q[0].m, exp_q[0].alu}) begin
      n_bad++;
      $display("FAIL final_fetch: got strobes=%h alu=%b want strobes=%h alu=%b",
               obs(), ALUCode, exp_q[0].m, exp_q[0].alu);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_br(1'b1);
    test_br(1'b0);
    test_st();
    test_halt();
    test_clear_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clock  input  1  sole clock; all state changes on posedge clock.
REQ-002 clear  input  1  synchronous, active-high reset.
REQ-003 IR  input  32  instruction register contents; opcode = IR[31:27].
REQ-004 ConOut  input  1  branch-condition flag from datapath CON_FF.
REQ-005 run  output  1  high unless in HALT.
REQ-006 PCIn / PCOut  output  1 each  PC load from bus / PC drive onto bus.
REQ-007 IRIn  output  1  IR load from bus.
REQ-008 MARIn  output  1  MAR load from bus.
REQ-009 MDRIn / MDROut  output  1 each  MDR load (bus, or memory when memread) / MDR drive.
REQ-010 YIn  output  1  Y load from bus.
REQ-011 ZIn / ZLoOut  output  1 each  Z load from ALU / Z low word drive.
REQ-012 COut  output  1  sign-extended constant C drive.
REQ-013 Gra, Grb, Grc  output  1 each  register-field select Ra/Rb/Rc.
REQ-014 RIn / ROut / BAOut  output  1 each  register write / read / base-address read (R0 reads 0).
REQ-015 Conin  output  1  CON_FF load.
REQ-016 memread / memwrite  output  1 each  memory strobes.
REQ-017 ALUCode  output  5  ALU operation; 5'b11111 = increment, 5'b00011 = add.
REQ-018 Hi/Lo/ZHi/OPort/IPort strobes are not driven by this block; tie-off to 0 is done at top level.

Function
REQ-019 Moore FSM: outputs are a pure decode of the registered state plus IR and ConOut; every state lasts exactly one clock.
REQ-020 Outputs not listed for a state are 0; ALUCode defaults to 5'b00000.
REQ-021 States: FETCH0, FETCH1, FETCH2, EX3, EX4, EX5, EX6, EX7, HALT.
REQ-022 FETCH0: PCOut MARIn ZIn ALUCode=11111. FETCH1: ZLoOut PCIn memread MDRIn. FETCH2: MDROut IRIn.
REQ-023 FETCH2 -> EX3 always; opcode decodes from IR in EX3 onward, never earlier.
REQ-024 R-type (add, sub, and, or): EX3 Grb ROut YIn; EX4 Grc ROut ZIn ALUCode=op; EX5 ZLoOut Gra RIn; -> FETCH0.
REQ-025 Immediate (addi, andi, ori): as REQ-024, but EX4 drives COut instead of Grc ROut.
REQ-026 ldi: EX3 Grb BAOut YIn; EX4 COut ZIn ALUCode=add; EX5 ZLoOut Gra RIn; -> FETCH0.
REQ-027 ld: EX3-EX4 as ldi; EX5 ZLoOut MARIn; EX6 memread MDRIn; EX7 MDROut Gra RIn; -> FETCH0.
REQ-028 st: EX3-EX5 as ld; EX6 Gra ROut MDRIn; EX7 memwrite; -> FETCH0.
REQ-029 br: EX3 Gra ROut Conin; EX4 PCOut YIn; EX5 COut ZIn ALUCode=add; EX6 ZLoOut PCIn only if ConOut=1; -> FETCH0.
REQ-030 ConOut is sampled combinationally in EX6 only. Branch-not-taken still takes EX6, so every branch costs 7 cycles.
REQ-031 halt: EX3 -> HALT; HALT holds with all strobes 0 and run=0 until clear.
REQ-032 Undefined opcode behaves as nop: EX3 -> FETCH0 with no strobes.
REQ-033 memread and memwrite are never high in the same cycle; RIn and ROut are never high in the same cycle.

Reset
REQ-034 clear high at a posedge sets state to FETCH0 on that edge; this holds mid-instruction and in HALT.
REQ-035 While clear is high, all outputs are 0 and run=1; fetch begins on the first edge after clear falls.

Structure
REQ-036 Opcode constants, ALUCode constants and the state enumeration live in shared package risc_pkg.
REQ-037 A single sub-module, op_decode (opcode -> instruction class plus ALUCode), is natural; the FSM stays in control_unit.

Verification
REQ-038 clear for 2 cycles, then IR held at add R1,R2,R3 -> FETCH0..EX5 strobes exactly per REQ-022/024, back in FETCH0 after 6 cycles.
REQ-039 ld R1,0x55(R2) -> EX5 MARIn, EX6 memread+MDRIn, EX7 Gra+RIn; instruction is 8 cycles.
REQ-040 br with ConOut=1, then ConOut=0 -> EX6 PCIn=1 then PCIn=0; both instructions are 7 cycles.
REQ-041 st -> memwrite=1 only in EX7; memread=0 throughout EX3-EX7.
REQ-042 halt -> run=0 from the cycle after EX3, all strobes 0 for 20 cycles; clear -> FETCH0.
REQ-043 clear asserted in EX5 of ld -> FETCH0 on the next edge; MARIn/MDRIn/RIn never asserted afterward for that instruction.
